// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg
// Shared constants for the seven-segment display path: glyph patterns for
// the hex digits (active-high, bit order {g,f,e,d,c,b,a}), the all-off
// active-low pattern, field widths and the capture classification used by
// the reader. The forward hex-to-segment decoder uses the same glyphs, so the
// reader and the decoder stay consistent with each other.
package seven_seg_pkg;

   localparam int NIBBLE_W = 4;
   localparam int SEG_W    = 7;

   localparam logic [SEG_W-1:0] GLYPH_0 = 7'h3F;
   localparam logic [SEG_W-1:0] GLYPH_1 = 7'h06;
   localparam logic [SEG_W-1:0] GLYPH_2 = 7'h5B;
   localparam logic [SEG_W-1:0] GLYPH_3 = 7'h4F;
   localparam logic [SEG_W-1:0] GLYPH_4 = 7'h66;
   localparam logic [SEG_W-1:0] GLYPH_5 = 7'h6D;
   localparam logic [SEG_W-1:0] GLYPH_6 = 7'h7D;
   localparam logic [SEG_W-1:0] GLYPH_7 = 7'h07;
   localparam logic [SEG_W-1:0] GLYPH_8 = 7'h7F;
   localparam logic [SEG_W-1:0] GLYPH_9 = 7'h6F;
   localparam logic [SEG_W-1:0] GLYPH_A = 7'h77;
   localparam logic [SEG_W-1:0] GLYPH_B = 7'h7C;
   localparam logic [SEG_W-1:0] GLYPH_C = 7'h39;
   localparam logic [SEG_W-1:0] GLYPH_D = 7'h5E;
   localparam logic [SEG_W-1:0] GLYPH_E = 7'h79;
   localparam logic [SEG_W-1:0] GLYPH_F = 7'h71;

   // Active-low bus value with every segment dark.
   localparam logic [SEG_W-1:0] SEG_BLANK_N = 7'h7F;

   // Outcome of one capture.
   typedef enum logic [1:0] {
      CAP_LEGAL   = 2'd0,
      CAP_BLANK   = 2'd1,
      CAP_ILLEGAL = 2'd2
   } capKind_t;

   // Active-high glyph for a nibble.
   function automatic logic [SEG_W-1:0] glyphOf(input logic [NIBBLE_W-1:0] nibble);
      logic [SEG_W-1:0] g;
      case (nibble)
         4'h0:    g = GLYPH_0;
         4'h1:    g = GLYPH_1;
         4'h2:    g = GLYPH_2;
         4'h3:    g = GLYPH_3;
         4'h4:    g = GLYPH_4;
         4'h5:    g = GLYPH_5;
         4'h6:    g = GLYPH_6;
         4'h7:    g = GLYPH_7;
         4'h8:    g = GLYPH_8;
         4'h9:    g = GLYPH_9;
         4'hA:    g = GLYPH_A;
         4'hB:    g = GLYPH_B;
         4'hC:    g = GLYPH_C;
         4'hD:    g = GLYPH_D;
         4'hE:    g = GLYPH_E;
         default: g = GLYPH_F;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/seven_segment_pattern_decoder.sv
// seven_segment_pattern_decoder
// Purely combinational inverse of the hex glyph table.
// Ports:
//   segN     in  7  active-low segment pattern {g,f,e,d,c,b,a}
//   nibble   out 4  hex value whose glyph matches (0 when no match)
//   hit      out 1  pattern is one of the 16 legal glyphs
//   is_blank out 1  pattern has every segment off
module seven_segment_pattern_decoder
   import seven_seg_pkg::*;
(
   input  logic [SEG_W-1:0]    segN,
   output logic [NIBBLE_W-1:0] nibble,
   output logic                hit,
   output logic                is_blank
);

   logic [SEG_W-1:0] segOn;

   assign segOn = ~segN;

   // The 16 glyphs are distinct, so at most one comparison can match.
   always_comb begin
      nibble = '0;
      hit    = 1'b0;
      for (int n = 0; n < 16; n++) begin
         if (glyphOf(NIBBLE_W'(n)) == segOn) begin
            nibble = NIBBLE_W'(n);
            hit    = 1'b1;
         end
      end
   end

   assign is_blank = (segN == SEG_BLANK_N);

endmodule

// File: rtl/seven_segment_reader.sv
// seven_segment_reader
// Watches a scanned, multiplexed, active-low seven-segment bus and recovers
// the hex nibble shown on each digit. A {digit_sel, seg_n} pair must be
// sampled unchanged STABLE_CYCLES times before it is captured, which hides
// scan ghosting. Each capture classifies the pattern as a legal glyph, a
// blank digit, or an illegal pattern, and a frame pulse marks that every
// digit has been refreshed since the previous frame.
// Ports:
//   clk          in  1             rising-edge clock
//   reset_n      in  1             synchronous active-low reset
//   seg_n        in  7             active-low segment bus {g,f,e,d,c,b,a}
//   digit_sel    in  NUM_DIGITS    one-hot select of the driven digit
//   value_out    out 4*NUM_DIGITS  recovered nibbles, digit i at [4i+3:4i]
//   digit_valid  out NUM_DIGITS    last capture of digit i was a legal glyph
//   blank        out NUM_DIGITS    last capture of digit i was all-off
//   error        out 1             one-cycle pulse: capture was illegal
//   frame_valid  out 1             one-cycle pulse: all digits captured
module seven_segment_reader
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS    = 6,
   parameter int STABLE_CYCLES = 4
)
(
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [SEG_W-1:0]               seg_n,
   input  logic [NUM_DIGITS-1:0]          digit_sel,
   output logic [NIBBLE_W*NUM_DIGITS-1:0] value_out,
   output logic [NUM_DIGITS-1:0]          digit_valid,
   output logic [NUM_DIGITS-1:0]          blank,
   output logic                           error,
   output logic                           frame_valid
);

   // One spare bit so the saturation value STABLE_CYCLES+1 fits for 255.
   localparam int                    CNT_W      = 9;
   localparam logic [CNT_W-1:0]      CNT_TARGET = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0]      CNT_SAT    = CNT_W'(STABLE_CYCLES + 1);
   localparam logic [NUM_DIGITS-1:0] ALL_SEEN   = '1;

   logic [NUM_DIGITS-1:0] selQ;
   logic [SEG_W-1:0]      segQ;
   logic [CNT_W-1:0]      stableCnt;
   logic [CNT_W-1:0]      stableCntNext;
   logic [NUM_DIGITS-1:0] seenMask;
   logic [NUM_DIGITS-1:0] seenNext;

   logic                  inSelOneHot;
   logic                  pairChanged;
   logic                  capture;
   logic                  frameDone;
   logic [NIBBLE_W-1:0]   decNibble;
   logic                  decHit;
   logic                  decBlank;
   capKind_t              capKind;

   seven_segment_pattern_decoder uDecoder (
      .segN     (segQ),
      .nibble   (decNibble),
      .hit      (decHit),
      .is_blank (decBlank)
   );

   assign inSelOneHot = (digit_sel != '0) &&
                        ((digit_sel & (digit_sel - NUM_DIGITS'(1))) == '0);
   assign pairChanged = ({digit_sel, seg_n} != {selQ, segQ});

   // stableCnt is the number of consecutive edges the registered pair has
   // held its current value. It only reaches CNT_TARGET with a one-hot
   // select, because an illegal select forces it to 0.
   assign capture = (stableCnt == CNT_TARGET);

   always_comb begin
      stableCntNext = stableCnt;
      if (!inSelOneHot) begin
         stableCntNext = '0;
      end else if (pairChanged) begin
         stableCntNext = CNT_W'(1);
      end else if (stableCnt >= CNT_TARGET) begin
         // Park past the target so a held pair is captured only once.
         stableCntNext = CNT_SAT;
      end else begin
         stableCntNext = stableCnt + CNT_W'(1);
      end
   end

   always_comb begin
      capKind = CAP_ILLEGAL;
      if (decHit) begin
         capKind = CAP_LEGAL;
      end else if (decBlank) begin
         capKind = CAP_BLANK;
      end
   end

   assign seenNext  = seenMask | selQ;
   assign frameDone = capture && (seenNext == ALL_SEEN);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         selQ        <= '0;
         segQ        <= '0;
         stableCnt   <= '0;
         seenMask    <= '0;
         value_out   <= '0;
         digit_valid <= '0;
         blank       <= '0;
         error       <= 1'b0;
         frame_valid <= 1'b0;
      end else begin
         selQ        <= digit_sel;
         segQ        <= seg_n;
         stableCnt   <= stableCntNext;
         error       <= 1'b0;
         frame_valid <= 1'b0;
         if (capture) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (selQ[i]) begin
                  case (capKind)
                     CAP_LEGAL: begin
                        value_out[NIBBLE_W*i +: NIBBLE_W] <= decNibble;
                        digit_valid[i] <= 1'b1;
                        blank[i]       <= 1'b0;
                     end
                     CAP_BLANK: begin
                        digit_valid[i] <= 1'b0;
                        blank[i]       <= 1'b1;
                     end
                     default: begin
                        digit_valid[i] <= 1'b0;
                        blank[i]       <= 1'b0;
                     end
                  endcase
               end
            end
            error <= (capKind == CAP_ILLEGAL);
            if (frameDone) begin
               frame_valid <= 1'b1;
               seenMask    <= '0;
            end else begin
               seenMask    <= seenNext;
            end
         end
      end
   end

endmodule

// File: tb/tb_seven_segment_reader.sv
// tb_seven_segment_reader
// Directed scenarios plus a randomized scan, checked against a history-based
// reference model: a pair is captured when the last STABLE_CYCLES samples
// since reset are identical, carry a one-hot select, and the sample just
// before them (if any) was different.
module tb_seven_segment_reader;

   localparam int ND = 6;
   localparam int SC = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [6:0]    seg_n = 7'h7F;
   logic [ND-1:0] digit_sel = '0;
   logic [4*ND-1:0] value_out;
   logic [ND-1:0] digit_valid;
   logic [ND-1:0] blank;
   logic          error;
   logic          frame_valid;

   int compared = 0;
   int mismatched = 0;

   logic [6:0] glyphTbl [16];

   // Reference model state.
   logic [4*ND-1:0] expValue;
   logic [ND-1:0]   expValid;
   logic [ND-1:0]   expBlank;
   logic            expError;
   logic            expFrame;
   logic [ND-1:0]   seenModel;
   logic [ND+6:0]   hist [$];
   logic [4*ND-1:0] expQ [$];

   seven_segment_reader #(
      .NUM_DIGITS    (ND),
      .STABLE_CYCLES (SC)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .seg_n       (seg_n),
      .digit_sel   (digit_sel),
      .value_out   (value_out),
      .digit_valid (digit_valid),
      .blank       (blank),
      .error       (error),
      .frame_valid (frame_valid)
   );

   // Clock.
   always #5 clk = ~clk;

   // Drive one cycle, advance the model across the edge, return 1 time unit
   // after the edge so outputs are sampled away from it.
   task automatic step(input logic rstN, input logic [ND-1:0] sel, input logic [6:0] seg);
      logic [ND+6:0] pair;
      logic [6:0]    on;
      bit            cap;
      bit            legal;
      int            idx;
      int            nib;
      reset_n   = rstN;
      digit_sel = sel;
      seg_n     = seg;
      @(posedge clk);
      expError = 1'b0;
      expFrame = 1'b0;
      if (!rstN) begin
         expValue  = '0;
         expValid  = '0;
         expBlank  = '0;
         seenModel = '0;
         hist.delete();
      end else begin
         cap  = 1'b0;
         pair = '0;
         if (hist.size() >= SC) begin
            pair = hist[hist.size()-1];
            cap  = 1'b1;
            for (int k = 1; k <= SC; k++)
               if (hist[hist.size()-k] != pair) cap = 1'b0;
            if (hist.size() > SC && hist[hist.size()-SC-1] == pair) cap = 1'b0;
            if ($countones(pair[ND+6:7]) != 1) cap = 1'b0;
         end
         if (cap) begin
            idx = 0;
            for (int d = 0; d < ND; d++) if (pair[7+d]) idx = d;
            on    = ~pair[6:0];
            legal = 1'b0;
            nib   = 0;
            for (int n = 0; n < 16; n++) if (glyphTbl[n] == on) begin legal = 1'b1; nib = n; end
            if (legal) begin
               expValue[4*idx +: 4] = 4'(nib);
               expValid[idx] = 1'b1;
               expBlank[idx] = 1'b0;
            end else if (pair[6:0] == 7'h7F) begin
               expValid[idx] = 1'b0;
               expBlank[idx] = 1'b1;
            end else begin
               expValid[idx] = 1'b0;
               expBlank[idx] = 1'b0;
               expError = 1'b1;
            end
            seenModel[idx] = 1'b1;
            if (seenModel == '1) begin
               expFrame  = 1'b1;
               seenModel = '0;
               expQ.push_back(expValue);
            end
         end
         hist.push_back({sel, seg});
         if (hist.size() > SC + 1) void'(hist.pop_front());
      end
      #1;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         step(1'b0, ND'($urandom), 7'($urandom));
         compared++;
         if ({value_out, digit_valid, blank, error, frame_valid} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %h required 0",
                     {value_out, digit_valid, blank, error, frame_valid});
         end
      end
      // First sample edge is k=1; capture lands on the fourth edge after it.
      for (int k = 1; k <= 9; k++) begin
         step(1'b1, 6'b000001, 7'h12);
         compared++;
         if (digit_valid[0] !== (k >= 5)) begin
            mismatched++;
            $display("FAIL reset_first_capture_k%0d: got %b required %b", k, digit_valid[0], k >= 5);
         end
         compared++;
         if (value_out[3:0] !== ((k >= 5) ? 4'h5 : 4'h0)) begin
            mismatched++;
            $display("FAIL reset_first_value_k%0d: got %h required %h", k, value_out[3:0], (k >= 5) ? 4'h5 : 4'h0);
         end
         compared++;
         if ({error, frame_valid} !== 2'b00) begin
            mismatched++;
            $display("FAIL reset_no_pulse_k%0d: got %b required 00", k, {error, frame_valid});
         end
      end
   endtask

   task automatic test_glitch();
      for (int k = 1; k <= 3; k++) begin
         step(1'b1, 6'b000010, 7'h40);
         compared++;
         if (digit_valid[1] !== 1'b0) begin
            mismatched++;
            $display("FAIL glitch_short_hold_k%0d: got %b required 0", k, digit_valid[1]);
         end
      end
      for (int k = 1; k <= 6; k++) begin
         step(1'b1, 6'b000010, 7'h79);
         compared++;
         if ({digit_valid[1], value_out[7:4], error} !== ((k >= 5) ? 6'b1_0001_0 : 6'b0_0000_0)) begin
            mismatched++;
            $display("FAIL glitch_capture_k%0d: got %b required %b", k,
                     {digit_valid[1], value_out[7:4], error}, (k >= 5) ? 6'b1_0001_0 : 6'b0_0000_0);
         end
      end
   endtask

   task automatic test_illegal_blank();
      int errCount;
      for (int k = 0; k < 6; k++) step(1'b1, 6'b000100, 7'h10);
      compared++;
      if (value_out[11:8] !== 4'h9) begin
         mismatched++;
         $display("FAIL illegal_setup_nine: got %h required 9", value_out[11:8]);
      end
      errCount = 0;
      for (int k = 1; k <= 7; k++) begin
         step(1'b1, 6'b000100, 7'h7E);
         if (error) errCount++;
         compared++;
         if (error !== (k == 5)) begin
            mismatched++;
            $display("FAIL illegal_error_pulse_k%0d: got %b required %b", k, error, k == 5);
         end
      end
      compared++;
      if ({errCount, digit_valid[2], blank[2], value_out[11:8]} !== {32'd1, 1'b0, 1'b0, 4'h9}) begin
         mismatched++;
         $display("FAIL illegal_retain: got cnt=%0d v=%b b=%b val=%h required cnt=1 v=0 b=0 val=9",
                  errCount, digit_valid[2], blank[2], value_out[11:8]);
      end
      errCount = 0;
      for (int k = 0; k < 7; k++) begin
         step(1'b1, 6'b000100, 7'h7F);
         if (error) errCount++;
      end
      compared++;
      if ({errCount, digit_valid[2], blank[2], value_out[11:8]} !== {32'd0, 1'b0, 1'b1, 4'h9}) begin
         mismatched++;
         $display("FAIL blank_capture: got cnt=%0d v=%b b=%b val=%h required cnt=0 v=0 b=1 val=9",
                  errCount, digit_valid[2], blank[2], value_out[11:8]);
      end
   endtask

   task automatic test_frame();
      int frames;
      int nib [ND];
      logic [4*ND-1:0] want;
      logic [ND-1:0]   sel;
      step(1'b0, '0, 7'h7F);
      step(1'b0, '0, 7'h7F);
      for (int pass = 0; pass < 2; pass++) begin
         frames = 0;
         want   = '0;
         for (int d = 0; d < ND; d++) begin
            nib[d] = (pass == 0) ? d + 1 : int'($urandom_range(0, 15));
            want[4*d +: 4] = 4'(nib[d]);
            sel = '0;
            sel[d] = 1'b1;
            for (int k = 1; k <= 8; k++) begin
               step(1'b1, sel, ~glyphTbl[nib[d]]);
               if (frame_valid) frames++;
               compared++;
               if (frame_valid !== (d == ND - 1 && k == 5)) begin
                  mismatched++;
                  $display("FAIL frame_pulse_p%0d_d%0d_k%0d: got %b required %b", pass, d, k,
                           frame_valid, d == ND - 1 && k == 5);
               end
            end
         end
         compared++;
         if ({frames, value_out, digit_valid, blank} !== {32'd1, want, 6'h3F, 6'h00}) begin
            mismatched++;
            $display("FAIL frame_result_p%0d: got n=%0d val=%h v=%h b=%h required n=1 val=%h v=3f b=00",
                     pass, frames, value_out, digit_valid, blank, want);
         end
      end
   endtask

   task automatic test_illegal_select();
      logic [4*ND+2*ND-1:0] snap;
      snap = {value_out, digit_valid, blank};
      for (int k = 0; k < 20; k++) begin
         step(1'b1, (k < 10) ? 6'b000000 : 6'b000011, 7'h00);
         compared++;
         if ({value_out, digit_valid, blank, error, frame_valid} !== {snap, 2'b00}) begin
            mismatched++;
            $display("FAIL illegal_select_k%0d: got %h required %h", k,
                     {value_out, digit_valid, blank, error, frame_valid}, {snap, 2'b00});
         end
      end
   endtask

   task automatic test_error_frame();
      step(1'b0, '0, 7'h7F);
      for (int d = 0; d < ND; d++) begin
         for (int k = 1; k <= 6; k++) begin
            step(1'b1, ND'(1) << d, (d == ND - 1) ? 7'h7E : ~glyphTbl[d]);
            compared++;
            if ({error, frame_valid} !== ((d == ND - 1 && k == 5) ? 2'b11 : 2'b00)) begin
               mismatched++;
               $display("FAIL error_frame_d%0d_k%0d: got %b required %b", d, k, {error, frame_valid},
                        (d == ND - 1 && k == 5) ? 2'b11 : 2'b00);
            end
         end
      end
   endtask

   task automatic test_reset_mid_window();
      step(1'b1, 6'b000001, 7'h78);
      step(1'b1, 6'b000001, 7'h78);
      step(1'b0, 6'b000001, 7'h78);
      compared++;
      if ({value_out, digit_valid, blank, error, frame_valid} !== '0) begin
         mismatched++;
         $display("FAIL midwin_reset: got %h required 0", {value_out, digit_valid, blank, error, frame_valid});
      end
      for (int k = 1; k <= 7; k++) begin
         step(1'b1, 6'b000001, 7'h78);
         compared++;
         if ({digit_valid[0], value_out[3:0]} !== ((k >= 5) ? 5'b1_0111 : 5'b0_0000)) begin
            mismatched++;
            $display("FAIL midwin_capture_k%0d: got %b required %b", k, {digit_valid[0], value_out[3:0]},
                     (k >= 5) ? 5'b1_0111 : 5'b0_0000);
         end
      end
   endtask

   task automatic test_random();
      logic [ND-1:0]   sel;
      logic [6:0]      seg;
      logic [4*ND-1:0] qv;
      int dwell;
      int r;
      expQ.delete();
      for (int t = 0; t < 300; t++) begin
         sel = '0;
         if ($urandom_range(0, 9) == 0) sel = ND'($urandom);
         else sel[$urandom_range(0, ND - 1)] = 1'b1;
         r = int'($urandom_range(0, 9));
         if (r < 7) seg = ~glyphTbl[$urandom_range(0, 15)];
         else if (r == 7) seg = 7'h7F;
         else seg = 7'($urandom);
         dwell = int'($urandom_range(1, 8));
         for (int k = 0; k < dwell; k++) begin
            step(($urandom_range(0, 79) != 0), sel, seg);
            compared++;
            if ({value_out, digit_valid, blank, error, frame_valid} !==
                {expValue, expValid, expBlank, expError, expFrame}) begin
               mismatched++;
               $display("FAIL random_t%0d: got %h required %h", t,
                        {value_out, digit_valid, blank, error, frame_valid},
                        {expValue, expValid, expBlank, expError, expFrame});
            end
            if (frame_valid === 1'b1) begin
               compared++;
               if (expQ.size() == 0) begin
                  mismatched++;
                  $display("FAIL random_frame_unexpected: got frame with value %h required none", value_out);
               end else begin
                  qv = expQ.pop_front();
                  if (value_out !== qv) begin
                     mismatched++;
                     $display("FAIL random_frame_value: got %h required %h", value_out, qv);
                  end
               end
            end
         end
      end
   endtask

   initial begin
      glyphTbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      expValue  = '0;
      expValid  = '0;
      expBlank  = '0;
      expError  = 1'b0;
      expFrame  = 1'b0;
      seenModel = '0;
      test_reset();
      test_glitch();
      test_illegal_blank();
      test_frame();
      test_illegal_select();
      test_error_frame();
      test_reset_mid_window();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/seven_segment_reader.md
Name: seven_segment_reader

Overview:
- Inverse of the team's hex-to-segment decoder: watches a scanned, multiplexed active-low seven-segment bus and recovers the hex nibble shown on each digit.
- Filters scan glitches with a stability counter and flags patterns that are not legal hex glyphs.
- Signals when every digit has been refreshed.
- Used as an on-chip display checker and as a bench monitor for the HEX display paths.

Parameters:
NUM_DIGITS, 6, number of multiplexed digits (width of digit_sel)
STABLE_CYCLES, 4, consecutive identical samples required before capture (legal range 1..255)

Ports:
clk  in  1  system clock; all logic on the rising edge
reset_n  in  1  synchronous, active-low reset
seg_n  in  7  active-low segment bus, format {g,f,e,d,c,b,a}
digit_sel  in  NUM_DIGITS  active-high one-hot select of the digit currently driven on seg_n
value_out  out  4*NUM_DIGITS  recovered nibbles; digit i occupies bits [4i+3:4i]
digit_valid  out  NUM_DIGITS  bit i is 1 when digit i's last capture was a legal glyph
blank  out  NUM_DIGITS  bit i is 1 when digit i's last capture was all segments off
error  out  1  one-cycle pulse: the last capture was an illegal pattern
frame_valid  out  1  one-cycle pulse: all digits captured since the previous frame

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - value_out=0, digit_valid=0, blank=0, error=0, frame_valid=0.
  - Seen mask, stability counter and input sample register are cleared.
  - Takes priority over every event, including a capture on the same edge.
- Input stage: {digit_sel, seg_n} is registered every cycle. No combinational path from inputs to outputs.
- Stability counter:
  - Counts consecutive cycles with the sampled pair unchanged; reloads to 1 on any change.
  - Saturates after capture, so there is exactly one capture per stable window.
  - A new capture requires the pair to change, then become stable again.
- Capture timing: if the pair is constant from edge E0 onward, outputs update at edge E0+STABLE_CYCLES.
- Illegal select: if the sampled digit_sel is zero or has more than one bit set, there is no capture and the counter holds at 0.
- Glyph table (active-high {g..a}): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71. seg_n is the bitwise inverse.
- Capture on digit i, three cases:
  - Legal glyph: value_out[i]=nibble, digit_valid[i]=1, blank[i]=0.
  - seg_n=7'h7F (all off): value_out[i] retained, digit_valid[i]=0, blank[i]=1, no error.
  - Any other pattern: value_out[i] retained, digit_valid[i]=0, blank[i]=0, error=1 for one cycle.
- Seen mask:
  - Every capture (legal, blank or illegal) sets seen[i].
  - When a capture completes the mask (all ones including the current digit), frame_valid pulses on that same output edge and the mask clears to 0.
- Repeated digit: capturing the same digit twice within a frame overwrites its outputs; the mask is unaffected.
- Pulse timing: error and frame_valid may assert in the same cycle; both are high for exactly one cycle.
- Reset mid-window: a partially counted window is discarded, and the pair must be re-held for a full STABLE_CYCLES after reset deasserts.
- STABLE_CYCLES=1: capture at edge E0+1; behaviour is otherwise identical.

Decomposition:
- Package seven_seg_pkg:
  - 16 glyph constants (active-high {g..a}).
  - SEG_BLANK_N = 7'h7F.
  - Nibble and segment widths.
  - Shared with the existing forward decoder.
- Sub-module seven_segment_pattern_decoder:
  - Purely combinational.
  - Input: 7-bit active-low pattern.
  - Outputs: nibble[3:0], hit, is_blank.
- Top module owns the input register, stability counter, one-hot check, per-digit storage, seen mask and pulses.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with arbitrary inputs -> all outputs 0; release, hold digit_sel=6'b000001, seg_n=7'h12 -> value_out[3:0]=5, digit_valid[0]=1 exactly 4 edges after first sample; no further capture while held.
- Glitch: digit_sel=6'b000010 with seg_n=7'h40 (0) held 3 cycles, then seg_n=7'h79 (1) held 4 -> only 1 captured into value_out[7:4]; no error.
- Illegal/blank: digit 2 with seg_n=7'h7E -> error one-cycle pulse, digit_valid[2]=0, value_out[11:8] unchanged; then seg_n=7'h7F -> blank[2]=1, no error.
- Frame: scan digits 0..5 showing 1,2,3,4,5,6 with 8-cycle dwell -> value_out=24'h654321, digit_valid=6'h3F, frame_valid pulses once at digit-5 capture; second pass pulses again.
- Illegal select: digit_sel=0, then 6'b000011, each held 10 cycles with seg_n=7'h00 -> no output change, no pulses.
- Reset mid-window: pair held 2 cycles, reset_n=0 for 1 cycle, pair held on -> capture 4 edges after reset release, not before.
